// File: rtl/writeback_pipe.sv
// writeback_pipe: valid-tagged delay line that tracks issued instructions
// through the execute latency. It raises the register-file write at the
// tail and exposes pending destinations to issue as a hazard scoreboard.
module writeback_pipe #(
  parameter int LEN_OPECODE = 6,
  parameter int LEN_REGNO   = 5,
  parameter int LEN_REG     = 32,
  parameter logic [LEN_OPECODE-1:0] OPECODE_CMP = 6'd10,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ST  = 6'd20,
  parameter logic [LEN_OPECODE-1:0] OPECODE_LD  = 6'd21,
  parameter int LATENCY = 1,
  parameter int NUM_SRC = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  input  logic [LEN_OPECODE-1:0]         opecode,
  input  logic [LEN_REGNO-1:0]           rd_regno,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [LEN_REG-1:0]             data_o,
  input  logic [LEN_REG-1:0]             data_o_forward,
  input  logic [NUM_SRC*LEN_REGNO-1:0]   rs_regno,
  output logic [NUM_SRC-1:0]             rs_pending,
  output logic                           is_wb,
  output logic [LEN_REGNO-1:0]           wb_regno,
  output logic [LEN_REG-1:0]             wb_data,
  output logic [3:0]                     inflight
);

  localparam int TAIL = LATENCY - 1;

  // Stage storage; index 0 is the entry stage, TAIL feeds the register file.
  logic [LATENCY-1:0]     stage_vld;
  logic [LEN_OPECODE-1:0] stage_op [LATENCY];
  logic [LEN_REGNO-1:0]   stage_rd [LATENCY];

  logic accept;
  logic tail_leaving;

  // Compares and stores produce no register result.
  function automatic logic writes(input logic [LEN_OPECODE-1:0] op);
    return (op != OPECODE_CMP) && (op != OPECODE_ST);
  endfunction

  assign accept       = valid_i & ~stall & ~flush;
  assign tail_leaving = stage_vld[TAIL] & ~stall;

  // Advance the pipeline; flush clears every valid even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        stage_op[k] <= '0;
        stage_rd[k] <= '0;
      end
    end else if (flush) begin
      stage_vld <= '0;
    end else if (!stall) begin
      stage_vld[0] <= accept;
      stage_op[0]  <= opecode;
      stage_rd[0]  <= rd_regno;
      for (int k = 1; k < LATENCY; k++) begin
        stage_vld[k] <= stage_vld[k-1];
        stage_op[k]  <= stage_op[k-1];
        stage_rd[k]  <= stage_rd[k-1];
      end
    end
  end

  // Occupancy tracks the popcount of the valid bits incrementally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + 4'(accept) - 4'(tail_leaving);
    end
  end

  // Tail writeback; load data comes from memory, everything else from the ALU.
  assign is_wb    = stage_vld[TAIL] & ~stall & writes(stage_op[TAIL]);
  assign wb_regno = stage_rd[TAIL];
  assign wb_data  = (stage_op[TAIL] == OPECODE_LD) ? data_o_forward : data_o;

  // Hazard scoreboard over registered state only; same-cycle input is ignored.
  always_comb begin
    rs_pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LATENCY; k++) begin
        if (stage_vld[k] && writes(stage_op[k]) &&
            (stage_rd[k] == rs_regno[i*LEN_REGNO +: LEN_REGNO])) begin
          rs_pending[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe with LATENCY=3.
module tb_writeback_pipe;

  localparam int LAT = 3;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_CMP = 6'd10;
  localparam logic [5:0] OP_ST  = 6'd20;
  localparam logic [5:0] OP_LD  = 6'd21;
  localparam logic [31:0] ALU_DATA = 32'h0000_1111;
  localparam logic [31:0] MEM_DATA = 32'h0000_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [5:0]  opecode = '0;
  logic [4:0]  rd_regno = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] data_o = ALU_DATA;
  logic [31:0] data_o_forward = MEM_DATA;
  logic [9:0]  rs_regno = '0;
  logic [1:0]  rs_pending;
  logic        is_wb;
  logic [4:0]  wb_regno;
  logic [31:0] wb_data;
  logic [3:0]  inflight;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  writeback_pipe #(
    .LEN_OPECODE(6), .LEN_REGNO(5), .LEN_REG(32),
    .OPECODE_CMP(OP_CMP), .OPECODE_ST(OP_ST), .OPECODE_LD(OP_LD),
    .LATENCY(LAT), .NUM_SRC(2)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opecode(opecode),
    .rd_regno(rd_regno), .stall(stall), .flush(flush), .data_o(data_o),
    .data_o_forward(data_o_forward), .rs_regno(rs_regno),
    .rs_pending(rs_pending), .is_wb(is_wb), .wb_regno(wb_regno),
    .wb_data(wb_data), .inflight(inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Drive one issue for the current cycle; queue its writeback if it should happen.
  task automatic issue(input logic [5:0] op, input logic [4:0] rd,
                       input int extra, input bit expect_wb);
    valid_i  = 1'b1;
    opecode  = op;
    rd_regno = rd;
    if (expect_wb && op != OP_CMP && op != OP_ST) begin
      sb.push_back('{cyc: cyc + LAT + extra, rd: rd,
                     data: (op == OP_LD) ? MEM_DATA : ALU_DATA});
    end
  endtask

  // Monitor: every writeback must match the head of the scoreboard.
  always @(negedge clk) begin
    if (is_wb) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_wb", {27'd0, wb_regno}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(cyc == e.cyc, "wb_cycle", cyc, e.cyc);
        check(wb_regno == e.rd, "wb_regno", {27'd0, wb_regno}, {27'd0, e.rd});
        check(wb_data == e.data, "wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    mid();
    check(is_wb == 1'b0, "rst_is_wb", {31'd0, is_wb}, 32'd0);
    check(inflight == 4'd0, "rst_inflight", {28'd0, inflight}, 32'd0);
    check(rs_pending == 2'b00, "rst_rs_pending", {30'd0, rs_pending}, 32'd0);
    check(wb_regno == 5'd0, "rst_wb_regno", {27'd0, wb_regno}, 32'd0);
    check(wb_data == ALU_DATA, "rst_wb_data", wb_data, ALU_DATA);
    step();
    rst = 1'b0;
    step();

    // Single ADD r5: pending in cycles 1..3, written in cycle 3
    rs_regno = {5'd0, 5'd5};
    issue(OP_ADD, 5'd5, 0, 1'b1);
    mid();
    check(rs_pending == 2'b00, "add_pending_c0", {30'd0, rs_pending}, 32'd0);
    step();
    valid_i = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      mid();
      check(rs_pending == 2'b01, "add_pending_inflight", {30'd0, rs_pending}, 32'd1);
      check(inflight == 4'd1, "add_inflight", {28'd0, inflight}, 32'd1);
      step();
    end
    mid();
    check(rs_pending == 2'b00, "add_pending_after", {30'd0, rs_pending}, 32'd0);
    check(inflight == 4'd0, "add_inflight_after", {28'd0, inflight}, 32'd0);
    step();

    // LD r2, CMP r3, ST r4: only LD writes, with memory data
    rs_regno = {5'd2, 5'd3};
    issue(OP_LD, 5'd2, 0, 1'b1);  step();
    issue(OP_CMP, 5'd3, 0, 1'b1); step();
    issue(OP_ST, 5'd4, 0, 1'b1);  step();
    valid_i = 1'b0;
    mid();
    check(rs_pending == 2'b10, "ld_cmp_pending", {30'd0, rs_pending}, 32'd2);
    check(inflight == 4'd3, "ld_cmp_st_inflight", {28'd0, inflight}, 32'd3);
    for (int k = 0; k < 5; k++) step();

    // Two stall cycles once three entries are in flight
    issue(OP_ADD, 5'd6, 2, 1'b1); step();
    issue(OP_ADD, 5'd7, 2, 1'b1); step();
    issue(OP_ADD, 5'd8, 2, 1'b1); step();
    valid_i = 1'b0;
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mid();
      check(inflight == 4'd3, "stall_inflight", {28'd0, inflight}, 32'd3);
      check(is_wb == 1'b0, "stall_is_wb", {31'd0, is_wb}, 32'd0);
      step();
    end
    stall = 1'b0;
    for (int k = 0; k < 5; k++) step();

    // Flush with the tail writing: tail writes, rest dropped
    rs_regno = {5'd11, 5'd10};
    issue(OP_ADD, 5'd9, 0, 1'b1);  step();
    issue(OP_ADD, 5'd10, 0, 1'b0); step();
    issue(OP_ADD, 5'd11, 0, 1'b0); step();
    valid_i = 1'b0;
    flush = 1'b1;
    mid();
    check(inflight == 4'd3, "flush_inflight_before", {28'd0, inflight}, 32'd3);
    check(rs_pending == 2'b11, "flush_pending_before", {30'd0, rs_pending}, 32'd3);
    step();
    flush = 1'b0;
    mid();
    check(inflight == 4'd0, "flush_inflight_after", {28'd0, inflight}, 32'd0);
    check(rs_pending == 2'b00, "flush_pending_after", {30'd0, rs_pending}, 32'd0);
    for (int k = 0; k < 4; k++) step();

    // Flush and stall together: no write, no accept
    rs_regno = {5'd15, 5'd14};
    issue(OP_ADD, 5'd12, 0, 1'b0); step();
    issue(OP_ADD, 5'd13, 0, 1'b0); step();
    issue(OP_ADD, 5'd14, 0, 1'b0); step();
    issue(OP_ADD, 5'd15, 0, 1'b0);
    flush = 1'b1;
    stall = 1'b1;
    mid();
    check(is_wb == 1'b0, "flush_stall_is_wb", {31'd0, is_wb}, 32'd0);
    check(rs_pending == 2'b01, "flush_stall_pending", {30'd0, rs_pending}, 32'd1);
    step();
    valid_i = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    mid();
    check(inflight == 4'd0, "flush_stall_inflight", {28'd0, inflight}, 32'd0);
    check(rs_pending == 2'b00, "flush_stall_no_accept", {30'd0, rs_pending}, 32'd0);
    for (int k = 0; k < 5; k++) step();

    // Asynchronous reset with two entries in flight, tail about to write
    rs_regno = {5'd17, 5'd16};
    issue(OP_ADD, 5'd16, 0, 1'b0); step();
    issue(OP_ADD, 5'd17, 0, 1'b0); step();
    valid_i = 1'b0;
    step();
    check(is_wb == 1'b1, "pre_rst_is_wb", {31'd0, is_wb}, 32'd1);
    check(rs_pending == 2'b11, "pre_rst_pending", {30'd0, rs_pending}, 32'd3);
    check(inflight == 4'd2, "pre_rst_inflight", {28'd0, inflight}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    check(is_wb == 1'b0, "async_rst_is_wb", {31'd0, is_wb}, 32'd0);
    check(rs_pending == 2'b00, "async_rst_pending", {30'd0, rs_pending}, 32'd0);
    check(inflight == 4'd0, "async_rst_inflight", {28'd0, inflight}, 32'd0);
    check(wb_regno == 5'd0, "async_rst_wb_regno", {27'd0, wb_regno}, 32'd0);
    step();
    rst = 1'b0;
    issue(OP_ADD, 5'd18, 0, 1'b1); step();
    valid_i = 1'b0;
    for (int k = 0; k < 6; k++) step();

    mid();
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
